// File: rtl/disp_arbiter.sv
// Display arbiter: grants the shared 4-digit 7-seg display to one of four
// requesters by fixed priority (index 0 highest). A granted pair is shown for
// HOLD ce ticks, after which the display falls back to the default pair.
//
// state | meaning
// IDLE  | no owner, display tracks def0/def1, any request is granted
// SHOW  | owner's latched pair on display, hold timer running on ce
module disp_arbiter #(
    parameter int W    = 16,
    parameter int HOLD = 400
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ce,
    input  logic [7:0]  def0,
    input  logic [7:0]  def1,
    input  logic [3:0]  req,
    input  logic [31:0] val0,
    input  logic [31:0] val1,
    output logic [3:0]  ack,
    output logic [7:0]  bin_out0,
    output logic [7:0]  bin_out1,
    output logic [1:0]  owner,
    output logic        busy
);

    typedef enum logic {IDLE, SHOW} state_t;

    localparam logic [W-1:0] HOLD_LAST = W'(HOLD - 1);

    state_t         state_q, state_d;
    logic [W-1:0]   cnt_q, cnt_d;
    logic [3:0]     ack_q, ack_d;
    logic [7:0]     bin0_q, bin0_d;
    logic [7:0]     bin1_q, bin1_d;
    logic [1:0]     owner_q, owner_d;
    logic           busy_q, busy_d;

    logic [3:0]     req_eff;
    logic           cand_vld;
    logic [1:0]     cand_idx;
    logic [4:0]     cand_lsb;
    logic           do_grant;

    // Mask a request during its own ack cycle so a requester that drops req
    // after seeing ack is not granted a second time.
    assign req_eff = req & ~ack_q;

    // Fixed-priority pick: lowest requesting index wins.
    always_comb begin
        cand_vld = 1'b1;
        cand_idx = 2'd0;
        if (req_eff[0]) begin
            cand_idx = 2'd0;
        end else if (req_eff[1]) begin
            cand_idx = 2'd1;
        end else if (req_eff[2]) begin
            cand_idx = 2'd2;
        end else if (req_eff[3]) begin
            cand_idx = 2'd3;
        end else begin
            cand_vld = 1'b0;
        end
    end

    assign cand_lsb = {cand_idx, 3'b000};

    // In SHOW only an equal-or-higher priority candidate may take over
    // (retrigger or preemption); lower priority waits for expiry.
    assign do_grant = cand_vld && ((state_q == IDLE) || (cand_idx <= owner_q));

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ack_d   = 4'b0000;
        bin0_d  = bin0_q;
        bin1_d  = bin1_q;
        owner_d = owner_q;
        busy_d  = busy_q;

        if (do_grant) begin
            state_d = SHOW;
            cnt_d   = '0;
            ack_d   = 4'b0001 << cand_idx;
            bin0_d  = val0[cand_lsb +: 8];
            bin1_d  = val1[cand_lsb +: 8];
            owner_d = cand_idx;
            busy_d  = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    bin0_d = def0;
                    bin1_d = def1;
                end
                SHOW: begin
                    if (ce) begin
                        if (cnt_q == HOLD_LAST) begin
                            state_d = IDLE;
                            cnt_d   = '0;
                            busy_d  = 1'b0;
                            bin0_d  = def0;
                            bin1_d  = def1;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ack_q   <= 4'b0000;
            bin0_q  <= 8'h00;
            bin1_q  <= 8'h00;
            owner_q <= 2'd0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            bin0_q  <= bin0_d;
            bin1_q  <= bin1_d;
            owner_q <= owner_d;
            busy_q  <= busy_d;
        end
    end

    assign ack      = ack_q;
    assign bin_out0 = bin0_q;
    assign bin_out1 = bin1_q;
    assign owner    = owner_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_disp_arbiter.sv
// Directed bench for disp_arbiter with HOLD=4.
module tb_disp_arbiter;

    logic        clk;
    logic        rst_n;
    logic        ce;
    logic [7:0]  def0;
    logic [7:0]  def1;
    logic [3:0]  req;
    logic [31:0] val0;
    logic [31:0] val1;
    logic [3:0]  ack;
    logic [7:0]  bin_out0;
    logic [7:0]  bin_out1;
    logic [1:0]  owner;
    logic        busy;

    disp_arbiter #(.W(16), .HOLD(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ce       (ce),
        .def0     (def0),
        .def1     (def1),
        .req      (req),
        .val0     (val0),
        .val1     (val1),
        .ack      (ack),
        .bin_out0 (bin_out0),
        .bin_out1 (bin_out1),
        .owner    (owner),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        ce;
        logic [3:0]  req;
        logic [31:0] v0;
        logic [31:0] v1;
        logic [7:0]  d0;
        logic [7:0]  d1;
        logic [3:0]  e_ack;
        logic [7:0]  e_b0;
        logic [7:0]  e_b1;
        logic [1:0]  e_own;
        logic        e_busy;
    } vec_t;

    localparam logic [31:0] VA = 32'h40_45_20_01;
    localparam logic [31:0] VB = 32'h41_67_21_02;
    localparam logic [31:0] VA_RT = 32'h40_45_99_01;
    localparam logic [31:0] VB_RT = 32'h41_67_AA_02;

    vec_t vecs[$];
    int   n_vec;
    int   n_bad;

    function automatic vec_t mk(logic r, logic c, logic [3:0] q, logic [31:0] a,
                                logic [31:0] b, logic [7:0] d0, logic [7:0] d1,
                                logic [3:0] ea, logic [7:0] e0, logic [7:0] e1,
                                logic [1:0] eo, logic eb);
        vec_t v;
        v.rst_n = r; v.ce = c; v.req = q; v.v0 = a; v.v1 = b; v.d0 = d0; v.d1 = d1;
        v.e_ack = ea; v.e_b0 = e0; v.e_b1 = e1; v.e_own = eo; v.e_busy = eb;
        return v;
    endfunction

    task automatic check(string name, logic [3:0] ea, logic [7:0] e0, logic [7:0] e1,
                         logic [1:0] eo, logic eb);
        n_vec++;
        if (ack !== ea || bin_out0 !== e0 || bin_out1 !== e1 || owner !== eo || busy !== eb) begin
            n_bad++;
            $display("FAIL %s: got ack=%b b0=%h b1=%h owner=%0d busy=%b, want ack=%b b0=%h b1=%h owner=%0d busy=%b",
                     name, ack, bin_out0, bin_out1, owner, busy, ea, e0, e1, eo, eb);
        end
    endtask

    task automatic apply(int idx, vec_t v);
        rst_n = v.rst_n; ce = v.ce; req = v.req; val0 = v.v0; val1 = v.v1;
        def0 = v.d0; def1 = v.d1;
        @(posedge clk);
        #1;
        check($sformatf("vec%0d", idx), v.e_ack, v.e_b0, v.e_b1, v.e_own, v.e_busy);
    endtask

    initial begin
        int cyc;
        n_vec = 0;
        n_bad = 0;
        rst_n = 1'b0; ce = 1'b0; req = 4'b0; val0 = VA; val1 = VB; def0 = 8'h12; def1 = 8'h34;

        //            rst ce req      v0     v1     d0     d1     ack      b0     b1     own  busy
        // reset and idle tracking
        vecs.push_back(mk(0, 0, 4'b0000, VA,    VB,    8'h12, 8'h34, 4'b0000, 8'h00, 8'h00, 2'd0, 0));
        vecs.push_back(mk(1, 0, 4'b0000, VA,    VB,    8'h12, 8'h34, 4'b0000, 8'h12, 8'h34, 2'd0, 0));
        vecs.push_back(mk(1, 0, 4'b0000, VA,    VB,    8'h56, 8'h78, 4'b0000, 8'h56, 8'h78, 2'd0, 0));
        vecs.push_back(mk(1, 0, 4'b0000, VA,    VB,    8'h12, 8'h34, 4'b0000, 8'h12, 8'h34, 2'd0, 0));
        // single grant of 2 (ce in grant cycle ignored), req held through ack is masked
        vecs.push_back(mk(1, 1, 4'b0100, VA,    VB,    8'h12, 8'h34, 4'b0100, 8'h45, 8'h67, 2'd2, 1));
        vecs.push_back(mk(1, 0, 4'b0100, VA,    VB,    8'h12, 8'h34, 4'b0000, 8'h45, 8'h67, 2'd2, 1));
        vecs.push_back(mk(1, 1, 4'b0000, VA,    VB,    8'h12, 8'h34, 4'b0000, 8'h45, 8'h67, 2'd2, 1));
        vecs.push_back(mk(1, 1, 4'b0000, VA,    VB,    8'h12, 8'h34, 4'b0000, 8'h45, 8'h67, 2'd2, 1));
        vecs.push_back(mk(1, 0, 4'b0000, VA,    VB,    8'h12, 8'h34, 4'b0000, 8'h45, 8'h67, 2'd2, 1));
        vecs.push_back(mk(1, 1, 4'b0000, VA,    VB,    8'h12, 8'h34, 4'b0000, 8'h45, 8'h67, 2'd2, 1));
        vecs.push_back(mk(1, 1, 4'b0000, VA,    VB,    8'h12, 8'h34, 4'b0000, 8'h12, 8'h34, 2'd2, 0));
        vecs.push_back(mk(1, 0, 4'b0000, VA,    VB,    8'h12, 8'h34, 4'b0000, 8'h12, 8'h34, 2'd2, 0));
        // preemption of 2 by 0, counter restarts
        vecs.push_back(mk(1, 0, 4'b0100, VA,    VB,    8'h12, 8'h34, 4'b0100, 8'h45, 8'h67, 2'd2, 1));
        vecs.push_back(mk(1, 1, 4'b0000, VA,    VB,    8'h12, 8'h34, 4'b0000, 8'h45, 8'h67, 2'd2, 1));
        vecs.push_back(mk(1, 1, 4'b0001, VA,    VB,    8'h12, 8'h34, 4'b0001, 8'h01, 8'h02, 2'd0, 1));
        vecs.push_back(mk(1, 1, 4'b0000, VA,    VB,    8'h12, 8'h34, 4'b0000, 8'h01, 8'h02, 2'd0, 1));
        vecs.push_back(mk(1, 1, 4'b0000, VA,    VB,    8'h12, 8'h34, 4'b0000, 8'h01, 8'h02, 2'd0, 1));
        vecs.push_back(mk(1, 1, 4'b0000, VA,    VB,    8'h12, 8'h34, 4'b0000, 8'h01, 8'h02, 2'd0, 1));
        vecs.push_back(mk(1, 1, 4'b0000, VA,    VB,    8'h12, 8'h34, 4'b0000, 8'h12, 8'h34, 2'd0, 0));
        // lower priority 3 waits behind owner 1, one default cycle between owners
        vecs.push_back(mk(1, 0, 4'b0010, VA,    VB,    8'h12, 8'h34, 4'b0010, 8'h20, 8'h21, 2'd1, 1));
        vecs.push_back(mk(1, 1, 4'b1000, VA,    VB,    8'h12, 8'h34, 4'b0000, 8'h20, 8'h21, 2'd1, 1));
        vecs.push_back(mk(1, 1, 4'b1000, VA,    VB,    8'h12, 8'h34, 4'b0000, 8'h20, 8'h21, 2'd1, 1));
        vecs.push_back(mk(1, 1, 4'b1000, VA,    VB,    8'h12, 8'h34, 4'b0000, 8'h20, 8'h21, 2'd1, 1));
        vecs.push_back(mk(1, 0, 4'b1000, VA,    VB,    8'h12, 8'h34, 4'b0000, 8'h20, 8'h21, 2'd1, 1));
        vecs.push_back(mk(1, 1, 4'b1000, VA,    VB,    8'h12, 8'h34, 4'b0000, 8'h12, 8'h34, 2'd1, 0));
        vecs.push_back(mk(1, 0, 4'b1000, VA,    VB,    8'h12, 8'h34, 4'b1000, 8'h40, 8'h41, 2'd3, 1));
        vecs.push_back(mk(1, 0, 4'b0000, VA,    VB,    8'h12, 8'h34, 4'b0000, 8'h40, 8'h41, 2'd3, 1));
        // retrigger of owner 1 on the expiry cycle; values latched afterwards
        vecs.push_back(mk(1, 0, 4'b0010, VA,    VB,    8'h12, 8'h34, 4'b0010, 8'h20, 8'h21, 2'd1, 1));
        vecs.push_back(mk(1, 1, 4'b0000, VA,    VB,    8'h12, 8'h34, 4'b0000, 8'h20, 8'h21, 2'd1, 1));
        vecs.push_back(mk(1, 1, 4'b0000, VA,    VB,    8'h12, 8'h34, 4'b0000, 8'h20, 8'h21, 2'd1, 1));
        vecs.push_back(mk(1, 1, 4'b0000, VA,    VB,    8'h12, 8'h34, 4'b0000, 8'h20, 8'h21, 2'd1, 1));
        vecs.push_back(mk(1, 1, 4'b0010, VA_RT, VB_RT, 8'h12, 8'h34, 4'b0010, 8'h99, 8'hAA, 2'd1, 1));
        vecs.push_back(mk(1, 1, 4'b0000, VA,    VB,    8'h12, 8'h34, 4'b0000, 8'h99, 8'hAA, 2'd1, 1));
        vecs.push_back(mk(1, 1, 4'b0000, VA,    VB,    8'h12, 8'h34, 4'b0000, 8'h99, 8'hAA, 2'd1, 1));
        vecs.push_back(mk(1, 1, 4'b0000, VA,    VB,    8'h12, 8'h34, 4'b0000, 8'h99, 8'hAA, 2'd1, 1));
        vecs.push_back(mk(1, 1, 4'b0000, VA,    VB,    8'h12, 8'h34, 4'b0000, 8'h12, 8'h34, 2'd1, 0));
        // reset while ack is pending, then clean idle
        vecs.push_back(mk(1, 0, 4'b0100, VA,    VB,    8'h12, 8'h34, 4'b0100, 8'h45, 8'h67, 2'd2, 1));
        vecs.push_back(mk(0, 1, 4'b0100, VA,    VB,    8'h12, 8'h34, 4'b0000, 8'h00, 8'h00, 2'd0, 0));
        vecs.push_back(mk(1, 0, 4'b0000, VA,    VB,    8'h12, 8'h34, 4'b0000, 8'h12, 8'h34, 2'd0, 0));
        // all request: priority 0 wins, the rest wait
        vecs.push_back(mk(1, 0, 4'b1111, VA,    VB,    8'h12, 8'h34, 4'b0001, 8'h01, 8'h02, 2'd0, 1));
        vecs.push_back(mk(1, 0, 4'b1110, VA,    VB,    8'h12, 8'h34, 4'b0000, 8'h01, 8'h02, 2'd0, 1));

        foreach (vecs[i]) apply(i, vecs[i]);

        // Hand sequence: continuous ce with 1..3 waiting; expiry after exactly
        // HOLD=4 pulses, one default cycle, then requester 1 is granted.
        req = 4'b1110; ce = 1'b1;
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (busy === 1'b1 && cyc < 50);
        n_vec++;
        if (cyc != 4) begin
            n_bad++;
            $display("FAIL hold_len: got %0d cycles, want 4", cyc);
        end
        check("expiry_defaults", 4'b0000, 8'h12, 8'h34, 2'd0, 1'b0);
        @(posedge clk);
        #1;
        check("grant_after_gap", 4'b0010, 8'h20, 8'h21, 2'd1, 1'b1);
        req = 4'b1100;
        @(posedge clk);
        #1;
        check("owner1_holds", 4'b0000, 8'h20, 8'h21, 2'd1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/disp_arbiter.md
Name: disp_arbiter

Overview:
- Schedules the shared 4-digit 7-segment display between four requesters (e.g. note number, velocity, parameter edit, error code).
- A granted requester's two 8-bit values are shown for a hold time, after which the display falls back to the default pair.
- Sits directly in front of the 8-bit-pair 7-seg multiplexer; bin_out0/bin_out1 drive its two binary inputs.
- The hold timer advances on the same prescaler enable that paces digit scanning.

Parameters:
- HOLD, 400: hold time in ce ticks; 2 s at a 200 Hz ce. Legal range 1..2^W-1.
- W, 16: hold counter width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous reset, active-low
- ce  in  1  timer tick enable, one-cycle pulse from the prescaler
- def0  in  8  default value for bin_out0, shown when idle
- def1  in  8  default value for bin_out1, shown when idle
- req  in  4  request per requester; level, held until ack
- val0  in  32  requester i's first value in bits [8i+7:8i]
- val1  in  32  requester i's second value in bits [8i+7:8i]
- ack  out  4  one-cycle grant acknowledge per requester
- bin_out0  out  8  value to display input 0
- bin_out1  out  8  value to display input 1
- owner  out  2  index of the requester currently shown; valid when busy=1
- busy  out  1  1 in SHOW, 0 in IDLE

Behaviour:
- All outputs are registered. Synchronous reset (rst_n=0 at a clk edge) forces:
  - state=IDLE, bin_out0=0, bin_out1=0, ack=0, owner=0, busy=0, hold counter=0.
  - Reset overrides any cycle in progress, including a pending ack.
- Request masking: req_eff[i] = req[i] & ~ack[i]. A request is ignored in the cycle its ack is high, so a requester dropping req after seeing ack is never double-granted.
- Arbitration: fixed priority, index 0 highest. The candidate is the lowest i with req_eff[i]=1.
- IDLE:
  - With no candidate: bin_out0<=def0 and bin_out1<=def1 every cycle (one-cycle latency from def inputs).
  - With a candidate i: grant.
- Grant of i, all on the same edge:
  - bin_out0<=val0[i], bin_out1<=val1[i].
  - ack[i]<=1 for exactly one cycle.
  - owner<=i, busy<=1, counter<=0, state<=SHOW.
  - The values are latched at grant and do not track val inputs afterwards.
- SHOW with owner k:
  - A candidate i with i<=k is granted immediately. i<k is preemption; i==k is retrigger, which reloads the values and restarts the hold.
  - A candidate i>k is not acked and waits; the requester keeps req high.
  - When no grant occurs and ce=1: if counter==HOLD-1, then state<=IDLE, busy<=0, counter<=0 and bin_out takes def0/def1 on that edge. Otherwise counter increments.
  - When ce=0 the counter holds.
- Simultaneous events:
  - Grant and expiry in the same cycle: the grant wins, the new owner is shown and the counter is 0.
  - A waiting lower-priority request is granted in the first cycle after expiry (IDLE evaluation). The display therefore shows defaults for exactly one cycle between owners.
- owner retains its last value in IDLE and is qualified only by busy.
- Hold duration is measured from grant to return to IDLE: exactly HOLD ce pulses, counting pulses in cycles after the grant edge. A ce in the grant cycle is not counted.
- ack is never asserted on more than one bit at a time.

Test Plan:
- Idle tracking (HOLD=4): after reset, def0=0x12, def1=0x34 → one cycle later bin_out0=0x12, bin_out1=0x34; busy=0, ack=0.
- Single grant and expiry (HOLD=4): req[2]=1 with val0[23:16]=0x45, val1[23:16]=0x67 → next edge ack=4'b0100 for 1 cycle, bin_out=0x45/0x67, owner=2, busy=1. After the 4th following ce pulse → busy=0, bin_out=def.
- Preemption: owner=2 in SHOW, req[0]=1 with values 0x01/0x02 → next edge ack=4'b0001, owner=0, bin_out=0x01/0x02, counter=0.
- Lower priority waits: owner=1 in SHOW, req[3] held high → no ack[3] until expiry. IDLE shows def for 1 cycle, then ack=4'b1000, owner=3.
- Retrigger plus simultaneous expiry: owner=1, counter=HOLD-1, ce=1 and req[1]=1 with new values 0x99/0xAA in the same cycle → ack[1]=1, busy stays 1, bin_out=0x99/0xAA, counter=0.
- Reset mid-SHOW: rst_n=0 for one edge while busy=1 and ack pending → all outputs 0, state IDLE. The next cycle shows def0/def1 with no stale ack.
